// File: rtl/boss_hp_ctrl.sv
// Boss hit-point controller: hitbox test, damage with an invulnerability window,
// hit/death pulses and combat phase, all registered on clk22.
module boss_hp_ctrl #(
  parameter int HP_MAX  = 450,
  parameter int DMG     = 10,
  parameter int BOSS_W  = 64,
  parameter int BOSS_H  = 48,
  parameter int INV_CYC = 4,
  parameter int PH2_HP  = 300,
  parameter int PH3_HP  = 150
) (
  input  logic       clk22,
  input  logic       rst,
  input  logic       gamestart,
  input  logic       boss,
  input  logic [9:0] bossx,
  input  logic [9:0] bossy,
  input  logic       bul_valid,
  input  logic [9:0] bul_x,
  input  logic [9:0] bul_y,
  output logic [9:0] bosshp,
  output logic       bul_hit,
  output logic       flash,
  output logic [1:0] phase,
  output logic       boss_dead
);

  localparam int CW = (INV_CYC > 1) ? $clog2(INV_CYC) : 1;

  localparam logic [9:0]  HP_MAX_V = 10'(HP_MAX);
  localparam logic [9:0]  DMG_V    = 10'(DMG);
  localparam logic [9:0]  PH2_V    = 10'(PH2_HP);
  localparam logic [9:0]  PH3_V    = 10'(PH3_HP);
  localparam logic [10:0] W_V      = 11'(BOSS_W);
  localparam logic [10:0] H_V      = 11'(BOSS_H);
  localparam logic [CW-1:0] CNT_LOAD = CW'(INV_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, COOL, DEAD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [10:0]   x_end;
  logic [10:0]   y_end;
  logic          in_box;
  logic [9:0]    hp_hit;
  logic [1:0]    ph_hit;
  logic [1:0]    ph_cur;

  function automatic logic [1:0] phase_of(input logic [9:0] hp);
    if (hp > PH2_V)      return 2'd1;
    else if (hp > PH3_V) return 2'd2;
    else if (hp != '0)   return 2'd3;
    else                 return 2'd0;
  endfunction

  // Box edges are formed one bit wider so a boss near x/y=1023 does not wrap.
  assign x_end  = {1'b0, bossx} + W_V;
  assign y_end  = {1'b0, bossy} + H_V;
  assign in_box = bul_valid
                  && (bul_x >= bossx) && ({1'b0, bul_x} < x_end)
                  && (bul_y >= bossy) && ({1'b0, bul_y} < y_end);

  assign hp_hit = (bosshp > DMG_V) ? bosshp - DMG_V : '0;
  assign ph_hit = phase_of(hp_hit);
  assign ph_cur = phase_of(bosshp);

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain updates within a cycle.
  always_ff @(posedge clk22) begin
    if (rst || gamestart) begin
      state     <= IDLE;
      cnt       <= '0;
      bosshp    <= HP_MAX_V;
      bul_hit   <= 1'b0;
      flash     <= 1'b0;
      phase     <= 2'd0;
      boss_dead <= 1'b0;
    end else begin
      bul_hit   <= 1'b0;
      boss_dead <= 1'b0;
      case (state)
        IDLE: begin
          if (boss) begin
            state <= ACTIVE;
            phase <= ph_cur;
          end
        end
        ACTIVE: begin
          if (!boss) begin
            state <= IDLE;
            phase <= 2'd0;
          end else if (in_box) begin
            bosshp  <= hp_hit;
            bul_hit <= 1'b1;
            if (hp_hit == '0) begin
              state     <= DEAD;
              boss_dead <= 1'b1;
              flash     <= 1'b0;
              phase     <= 2'd0;
            end else begin
              state <= COOL;
              cnt   <= CNT_LOAD;
              flash <= 1'b1;
              phase <= ph_hit;
            end
          end
        end
        COOL: begin
          if (!boss) begin
            state <= IDLE;
            flash <= 1'b0;
            phase <= 2'd0;
          end else if (cnt == '0) begin
            state <= ACTIVE;
            flash <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DEAD: begin
          bosshp <= '0;
          flash  <= 1'b0;
          phase  <= 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
